// File: rtl/mux2_1_2bit_arbiter.sv
// Round-robin arbiter for two valid/ready requesters sharing one registered 2:1 mux output.
// Define MUX_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/1).
module mux2_1_2bit_arbiter #(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             selec,
  output logic             busy
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [BC_W-1:0]  r_beat_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_granted;
  logic             w_gnt_id;
  logic             w_out_free;
  logic             w_own_valid;
  logic             w_oth_valid;
  logic [WIDTH-1:0] w_own_data;
  logic             w_xfer;
  logic [BC_W-1:0]  w_cnt_inc;
  logic             w_burst_done;
  logic             w_release;
  logic             w_enter;
  logic             w_enter_id;

  assign w_granted    = (r_state != IDLE);
  assign w_gnt_id     = (r_state == GRANT1);
  assign w_out_free   = !r_out_valid || out_ready;
  assign w_own_valid  = w_gnt_id ? req1_valid : req0_valid;
  assign w_oth_valid  = w_gnt_id ? req0_valid : req1_valid;
  assign w_own_data   = w_gnt_id ? req1_data : req0_data;

  assign req0_ready   = (r_state == GRANT0) && w_out_free;
  assign req1_ready   = (r_state == GRANT1) && w_out_free;
  assign w_xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign w_cnt_inc    = r_beat_cnt + BC_W'(1);
  assign w_burst_done = w_xfer && (w_cnt_inc == BC_W'(MAX_BURST));
  assign w_release    = !w_own_valid || w_burst_done;

  // Next grant target: fresh arbitration from IDLE, or hand-over / re-grant on release.
  always_comb begin
    w_enter    = 1'b0;
    w_enter_id = 1'b0;
    case (r_state)
      IDLE: begin
        w_enter    = req0_valid || req1_valid;
        w_enter_id = (req0_valid && req1_valid) ? !r_last_grant : req1_valid;
      end
      GRANT0, GRANT1: begin
        if (w_release) begin
          if (w_oth_valid) begin
            w_enter    = 1'b1;
            w_enter_id = !w_gnt_id;
          end else if (w_burst_done) begin
            w_enter    = 1'b1;
            w_enter_id = w_gnt_id;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      if (w_enter) begin
        r_state      <= w_enter_id ? GRANT1 : GRANT0;
        r_last_grant <= w_enter_id;
        r_beat_cnt   <= '0;
      end else if (w_granted && w_release) begin
        r_state      <= IDLE;
        r_beat_cnt   <= '0;
      end else if (w_xfer) begin
        r_beat_cnt   <= w_cnt_inc;
      end

      if (w_xfer) begin
        r_out_data  <= w_own_data;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign selec     = w_gnt_id;
  assign busy      = w_granted;

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] r_grant_cnt0;
  logic [CNT_W-1:0] r_grant_cnt1;

  // Counts every grant entry, including a re-grant after a full burst.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else if (w_enter) begin
      if (!w_enter_id && (r_grant_cnt0 != '1)) r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
      if (w_enter_id && (r_grant_cnt1 != '1))  r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_mux2_1_2bit_arbiter.sv
// Bench for mux2_1_2bit_arbiter: transaction-level arbitration model checked every cycle,
// producer queues with an in-order scoreboard, and directed literal expectations.
module tb_mux2_1_2bit_arbiter;
  localparam int WIDTH     = 2;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             reset_L = 1'b0;
  logic             req0_valid = 1'b0;
  logic [WIDTH-1:0] req0_data = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [WIDTH-1:0] req1_data = '0;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             selec;
  logic             busy;
`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
`endif

  mux2_1_2bit_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .selec(selec), .busy(busy)
`ifdef MUX_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner of the channel (-1 = nobody), who was served last, beats taken in this grant.
  int m_owner = -1;
  int m_prev  = 1;
  int m_taken = 0;
  bit m_ov    = 1'b0;
  int m_od    = 0;
  int m_gc [2] = '{0, 0};

  function automatic void m_grant(input int n);
    m_owner = n;
    m_prev  = n;
    m_taken = 0;
    if (m_gc[n] < (1 << CNT_W) - 1) m_gc[n]++;
  endfunction

  function automatic void model_tick();
    bit v [2];
    int d [2];
    bit took;
    v[0] = req0_valid; v[1] = req1_valid;
    d[0] = int'(req0_data); d[1] = int'(req1_data);
    took = 1'b0;
    if (m_owner >= 0) took = v[m_owner] && (!m_ov || out_ready);
    if (took) begin
      m_od = d[m_owner];
      m_ov = 1'b1;
      m_taken++;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (m_owner < 0) begin
      if (v[0] && v[1]) m_grant(1 - m_prev);
      else if (v[0])    m_grant(0);
      else if (v[1])    m_grant(1);
    end else if (!v[m_owner] || m_taken == MAX_BURST) begin
      if (v[1 - m_owner])  m_grant(1 - m_owner);
      else if (v[m_owner]) m_grant(m_owner);
      else                 m_owner = -1;
    end
  endfunction

  always @(posedge clk) begin
    if (!reset_L) begin
      m_owner = -1; m_prev = 1; m_taken = 0; m_ov = 1'b0; m_od = 0; m_gc = '{0, 0};
    end else begin
      model_tick();
    end
  end

  // Per-cycle comparison against the model, after inputs for the cycle have settled.
  always @(negedge clk) begin
    logic e_ov, e_sel, e_busy, e_r0, e_r1;
    int   e_od, e_g0, e_g1;
    #2;
    if (!reset_L) begin
      e_ov = 0; e_od = 0; e_sel = 0; e_busy = 0; e_r0 = 0; e_r1 = 0; e_g0 = 0; e_g1 = 0;
    end else begin
      e_ov   = m_ov;
      e_od   = m_od;
      e_sel  = (m_owner == 1);
      e_busy = (m_owner >= 0);
      e_r0   = (m_owner == 0) && (!m_ov || out_ready);
      e_r1   = (m_owner == 1) && (!m_ov || out_ready);
      e_g0   = m_gc[0];
      e_g1   = m_gc[1];
    end
    chk("cyc_out_valid", 32'(out_valid), 32'(e_ov));
    chk("cyc_out_data", 32'(out_data), e_od);
    chk("cyc_selec", 32'(selec), 32'(e_sel));
    chk("cyc_busy", 32'(busy), 32'(e_busy));
    chk("cyc_req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("cyc_req1_ready", 32'(req1_ready), 32'(e_r1));
`ifdef MUX_ARB_STATS_EN
    chk("cyc_grant_cnt0", 32'(grant_cnt0), e_g0);
    chk("cyc_grant_cnt1", 32'(grant_cnt1), e_g1);
`else
    if (e_g0 + e_g1 < 0) $display("model grant count overflow");
`endif
  end

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] out_log [$];

  // One clock cycle: producers present queue heads, scoreboard checks delivered beats.
  task automatic step(input logic ordy);
    @(negedge clk);
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : '0;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : '0;
    out_ready  = ordy;
    #3;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        chk("sb_beat_order", 32'(out_data), 32'(sb[0]));
        void'(sb.pop_front());
      end
      out_log.push_back(out_data);
    end
    if (req0_valid && req0_ready) begin sb.push_back(q0[0]); void'(q0.pop_front()); end
    if (req1_valid && req1_ready) begin sb.push_back(q1[0]); void'(q1.pop_front()); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_selec", 32'(selec), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    q0.delete(); q1.delete(); sb.delete();
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    reset_L = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single requester: first beat visible two cycles after valid.
    q0.push_back(2'b10);
    step(1'b1); chk("single_idle_busy", 32'(busy), 0);
    step(1'b1); chk("single_grant_busy", 32'(busy), 1);
                chk("single_grant_selec", 32'(selec), 0);
                chk("single_grant_ready", 32'(req0_ready), 1);
    step(1'b1); chk("single_out_valid", 32'(out_valid), 1);
                chk("single_out_data", 32'(out_data), 2);
    step(1'b1); chk("single_drain_valid", 32'(out_valid), 0);
                chk("single_drain_busy", 32'(busy), 0);

    // Contention: 4 beats of req0 then 4 of req1, repeating.
    do_reset();
    for (int i = 0; i < 20; i++) begin q0.push_back(2'b01); q1.push_back(2'b10); end
    out_log.delete();
    for (int i = 0; i < 18; i++) step(1'b1);
    chk("contention_beats", 32'(out_log.size()), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      chk("contention_pattern", 32'(out_log[i]), ((i / 4) % 2 == 0) ? 1 : 2);

    // Reset while both requesters are streaming, then stay idle with no requests.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1); chk("post_rst_idle", 32'(busy), 0);
    end

    // Back-pressure for three cycles while the first beat sits in the output register.
    q0.push_back(2'b11); q0.push_back(2'b01); q0.push_back(2'b10); q0.push_back(2'b00);
    out_log.delete();
    begin
      logic ordy_pat [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
      for (int i = 0; i < 12; i++) begin
        step(ordy_pat[i]);
        if (i >= 2 && i <= 4) begin
          chk("bp_hold_valid", 32'(out_valid), 1);
          chk("bp_hold_data", 32'(out_data), 3);
          chk("bp_stall_ready", 32'(req0_ready), 0);
        end
      end
    end
    chk("bp_beats", 32'(out_log.size()), 4);
    chk("bp_sb_empty", 32'(sb.size()), 0);

    // Early release: req1 sends 2 beats and drops while req0 waits.
    q1.push_back(2'b01); q1.push_back(2'b10);
    step(1'b1);
    q0.push_back(2'b11); q0.push_back(2'b11); q0.push_back(2'b11);
    step(1'b1); chk("early_g1_selec", 32'(selec), 1);
    step(1'b1);
    step(1'b1); chk("early_release_selec", 32'(selec), 1);
                chk("early_release_busy", 32'(busy), 1);
    step(1'b1); chk("early_switch_selec", 32'(selec), 0);
                chk("early_switch_busy", 32'(busy), 1);
    for (int i = 0; i < 6; i++) step(1'b1);
    chk("early_sb_empty", 32'(sb.size()), 0);
    chk("early_q0_empty", 32'(q0.size()), 0);

`ifdef MUX_ARB_STATS_EN
    // Grants 0,1,0,1,0 then saturation of grant_cnt0.
    do_reset();
    for (int i = 0; i < 11; i++) q0.push_back(2'b01);
    for (int i = 0; i < 8; i++)  q1.push_back(2'b10);
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("stats_cnt0", 32'(grant_cnt0), 3);
    chk("stats_cnt1", 32'(grant_cnt1), 2);
    for (int i = 0; i < 260; i++) begin
      q0.push_back(2'b01);
      step(1'b1); step(1'b1); step(1'b1);
    end
    chk("stats_sat0", 32'(grant_cnt0), 255);
    chk("stats_hold1", 32'(grant_cnt1), 2);
`endif

    step(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
